// File: rtl/serial_negate_mc_pkg.sv
// Shared constants and framing state type for the multi-lane serial negator.
package serial_negate_mc_pkg;
  localparam int CH_DEF = 4;
  localparam int W_DEF  = 8;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;
endpackage

// File: rtl/serial_negate_mc_lane.sv
// One serial lane: LSB-first two's-complement negate (copy through first 1, invert after).
module serial_negate_lane
  import serial_negate_mc_pkg::*;
(
  input  logic t_clk,
  input  logic r_n,
  input  logic proc_i,
  input  logic first_i,
  input  logic last_i,
  input  logic bit_i,
  input  logic neg_en_i,
  output logic y_o,
  output logic ovf_o
);

  logic seen_q, seen_d;
  logic neg_q, neg_d;
  logic y_q, y_d;
  logic ovf_q, ovf_d;
  logic neg_eff, seen_eff;

  // On bit 0 the fresh enable applies and the history is empty.
  always_comb begin
    neg_eff  = first_i ? neg_en_i : neg_q;
    seen_eff = first_i ? 1'b0 : seen_q;
    seen_d   = seen_q;
    neg_d    = neg_q;
    y_d      = 1'b0;
    ovf_d    = 1'b0;
    if (proc_i) begin
      seen_d = seen_eff | bit_i;
      neg_d  = neg_eff;
      y_d    = bit_i ^ (neg_eff & seen_eff);
      ovf_d  = last_i & neg_eff & bit_i & ~seen_eff;
    end
  end

  always_ff @(posedge t_clk or negedge r_n) begin
    if (!r_n) begin
      seen_q <= 1'b0;
      neg_q  <= 1'b0;
      y_q    <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      seen_q <= seen_d;
      neg_q  <= neg_d;
      y_q    <= y_d;
      ovf_q  <= ovf_d;
    end
  end

  assign y_o   = y_q;
  assign ovf_o = ovf_q;

endmodule

// File: rtl/serial_negate_mc.sv
// Multi-lane serial two's-complement negator with shared sof framing and 1-cycle latency.
module serial_negate_mc
  import serial_negate_mc_pkg::*;
#(
  parameter int CH = CH_DEF,
  parameter int W  = W_DEF
) (
  input  logic          t_clk,
  input  logic          r_n,
  input  logic          in_valid,
  input  logic          sof,
  input  logic [CH-1:0] i,
  input  logic [CH-1:0] neg_en,
  output logic [CH-1:0] y,
  output logic          out_valid,
  output logic          out_sof,
  output logic          out_eow,
  output logic [CH-1:0] ovf,
  output logic          frame_err
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          first, proc, last, abort;
  logic          vld_q, sof_q, eow_q, ferr_q;

  always_comb begin
    first   = in_valid & sof;
    proc    = first | (in_valid & (state_q == RUN));
    last    = proc & ~first & (cnt_q == CW'(W - 1));
    abort   = first & (state_q == RUN);
    state_d = state_q;
    cnt_d   = cnt_q;
    if (first) begin
      state_d = RUN;
      cnt_d   = CW'(1);
    end else if (proc) begin
      if (last) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge t_clk or negedge r_n) begin
    if (!r_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      vld_q   <= 1'b0;
      sof_q   <= 1'b0;
      eow_q   <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      vld_q   <= proc;
      sof_q   <= first;
      eow_q   <= last;
      ferr_q  <= abort;
    end
  end

  for (genvar c = 0; c < CH; c++) begin : g_lane
    serial_negate_lane u_lane (
      .t_clk   (t_clk),
      .r_n     (r_n),
      .proc_i  (proc),
      .first_i (first),
      .last_i  (last),
      .bit_i   (i[c]),
      .neg_en_i(neg_en[c]),
      .y_o     (y[c]),
      .ovf_o   (ovf[c])
    );
  end

  assign out_valid = vld_q;
  assign out_sof   = sof_q;
  assign out_eow   = eow_q;
  assign frame_err = ferr_q;

endmodule

// File: tb/tb_serial_negate_mc.sv
// Scoreboard bench: word-level arithmetic model feeds a queue, a monitor checks every output beat.
module tb_serial_negate_mc;
  localparam int CH = 4;
  localparam int W  = 8;

  logic          t_clk = 1'b0;
  logic          r_n;
  logic          in_valid, sof;
  logic [CH-1:0] i, neg_en;
  logic [CH-1:0] y, ovf;
  logic          out_valid, out_sof, out_eow, frame_err;

  serial_negate_mc #(.CH(CH), .W(W)) dut (
    .t_clk(t_clk), .r_n(r_n), .in_valid(in_valid), .sof(sof), .i(i),
    .neg_en(neg_en), .y(y), .out_valid(out_valid), .out_sof(out_sof),
    .out_eow(out_eow), .ovf(ovf), .frame_err(frame_err)
  );

  always #5 t_clk = ~t_clk;

  typedef struct packed {
    logic [CH-1:0] y;
    logic          sof;
    logic          eow;
    logic [CH-1:0] ovf;
    logic          ferr;
  } exp_t;

  exp_t q[$];
  int   errs = 0;
  int   checks = 0;
  int   cyc = 0;

  // reference model state: accumulated input value per lane
  bit            m_in = 0;
  int            m_k = 0;
  int            m_acc[CH];
  logic [CH-1:0] m_neg = '0;

  // monitor observations
  int                  vld_cnt = 0, eow_cnt = 0, ferr_cnt = 0;
  int                  sof_cyc = 0, eow_cyc = 0, prev_eow_cyc = 0, sof_issue = 0;
  int                  mo_idx = 0;
  logic [CH-1:0][W-1:0] mo_acc = '0, last_words = '0, prev_words = '0;
  logic [CH-1:0]       last_ovf = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(posedge t_clk) cyc++;

  always @(negedge t_clk) begin
    exp_t e;
    if (out_valid) begin
      vld_cnt++;
      if (q.size() == 0) begin
        checks++;
        errs++;
        $display("FAIL unexpected_out: got out_valid=1 expected no output (t=%0t)", $time);
      end else begin
        e = q.pop_front();
        chk("y", 32'(y), 32'(e.y));
        chk("flags", 32'({out_sof, out_eow, ovf, frame_err}), 32'({e.sof, e.eow, e.ovf, e.ferr}));
      end
      if (out_sof) begin
        mo_idx  = 0;
        sof_cyc = cyc;
      end
      for (int c = 0; c < CH; c++) if (mo_idx < W) mo_acc[c][mo_idx] = y[c];
      mo_idx++;
      if (frame_err) ferr_cnt++;
      if (out_eow) begin
        eow_cnt++;
        prev_eow_cyc = eow_cyc;
        eow_cyc      = cyc;
        prev_words   = last_words;
        last_words   = mo_acc;
        last_ovf     = ovf;
      end
    end else begin
      chk("idle_flags", 32'({out_sof, out_eow, ovf, frame_err}), 32'd0);
    end
  end

  task automatic beat(input logic v, input logic s, input logic [CH-1:0] d, input logic [CH-1:0] n);
    exp_t e;
    logic ab;
    int   res;
    @(posedge t_clk);
    #1;
    in_valid = v; sof = s; i = d; neg_en = n;
    if (v) begin
      ab = 1'b0;
      if (s) begin
        ab    = m_in;
        m_in  = 1;
        m_k   = 0;
        m_neg = n;
        for (int c = 0; c < CH; c++) m_acc[c] = 0;
      end
      if (m_in) begin
        e = '0;
        for (int c = 0; c < CH; c++) begin
          m_acc[c] = m_acc[c] | (int'(d[c]) << m_k);
          res      = m_neg[c] ? -m_acc[c] : m_acc[c];
          e.y[c]   = res[m_k];
          e.ovf[c] = (m_k == W - 1) && m_neg[c] && (m_acc[c] == (1 << (W - 1)));
        end
        e.sof  = (m_k == 0);
        e.eow  = (m_k == W - 1);
        e.ferr = ab;
        q.push_back(e);
        m_k++;
        if (m_k == W) m_in = 0;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) beat(1'b0, 1'b0, '0, '0);
  endtask

  task automatic send_word(input logic [CH-1:0][W-1:0] wd, input logic [CH-1:0] n,
                           input int nbits, input int stall_at, input int stall_n);
    logic [CH-1:0] b;
    for (int k = 0; k < nbits; k++) begin
      for (int c = 0; c < CH; c++) b[c] = wd[c][k];
      beat(1'b1, k == 0, b, n);
      if (k == 0) sof_issue = cyc;
      if (k == stall_at) idle(stall_n);
    end
  endtask

  task automatic do_reset();
    @(negedge t_clk);
    #1;
    r_n = 1'b0;
    in_valid = 1'b0; sof = 1'b0;
    #1;
    chk("rst_async", 32'({y, out_valid, out_sof, out_eow, ovf, frame_err}), 32'd0);
    q.delete();
    m_in = 0;
    #20;
    r_n = 1'b1;
  endtask

  initial begin
    int v0, e0, f0;
    r_n = 1'b0; in_valid = 1'b0; sof = 1'b0; i = '0; neg_en = '0;
    #12;
    chk("reset_state", 32'({y, out_valid, out_sof, out_eow, ovf, frame_err}), 32'd0);
    #7;
    r_n = 1'b1;

    // beats before any sof are discarded
    v0 = vld_cnt;
    for (int k = 0; k < 5; k++) beat(1'b1, 1'b0, 4'($urandom), 4'($urandom));
    idle(2);
    chk("pre_sof_quiet", 32'(vld_cnt - v0), 32'd0);

    // mixed lanes incl. -128 overflow and zero
    send_word({8'h5A, 8'h00, 8'h80, 8'h05}, 4'b0111, W, -1, 0);
    idle(2);
    chk("words_basic", 32'(last_words), 32'h5A0080FB);
    chk("ovf_basic", 32'(last_ovf), 32'b0010);
    chk("sof_latency", 32'(sof_cyc - sof_issue), 32'd1);

    // stall three cycles after bit 3
    e0 = eow_cnt;
    send_word({8'h5A, 8'h00, 8'h80, 8'h05}, 4'b0111, W, 3, 3);
    idle(2);
    chk("words_stall", 32'(last_words), 32'h5A0080FB);
    chk("eow_once_stall", 32'(eow_cnt - e0), 32'd1);
    chk("stall_span", 32'(eow_cyc - sof_cyc), 32'd10);

    // back-to-back words
    send_word({4{8'h01}}, 4'b1111, W, -1, 0);
    send_word({4{8'hFF}}, 4'b1111, W, -1, 0);
    idle(2);
    chk("b2b_first", 32'(prev_words), 32'hFFFFFFFF);
    chk("b2b_second", 32'(last_words), 32'h01010101);
    chk("b2b_spacing", 32'(eow_cyc - prev_eow_cyc), 32'd8);

    // abort at bit 4, restart with fresh neg_en
    e0 = eow_cnt; f0 = ferr_cnt;
    send_word({4{8'h7C}}, 4'b0000, 4, -1, 0);
    send_word({4{8'h03}}, 4'b1111, W, -1, 0);
    idle(2);
    chk("abort_ferr", 32'(ferr_cnt - f0), 32'd1);
    chk("abort_eow", 32'(eow_cnt - e0), 32'd1);
    chk("abort_word", 32'(last_words), 32'hFDFDFDFD);

    // reset mid-word at bit 3
    send_word({4{8'h33}}, 4'b1111, 4, -1, 0);
    do_reset();
    v0 = vld_cnt;
    for (int k = 0; k < 4; k++) beat(1'b1, 1'b0, 4'($urandom), 4'($urandom));
    idle(2);
    chk("post_rst_quiet", 32'(vld_cnt - v0), 32'd0);
    send_word({8'h05, 8'h80, 8'h00, 8'h7F}, 4'b1111, W, -1, 0);
    idle(2);
    chk("post_rst_word", 32'(last_words), 32'hFB800081);
    chk("post_rst_ovf", 32'(last_ovf), 32'b0100);

    // random beats with occasional sof (aborts and stalls included)
    for (int k = 0; k < 400; k++)
      beat(($urandom % 4) != 0, ($urandom % 9) == 0, 4'($urandom), 4'($urandom));
    idle(4);
    chk("queue_drained", 32'(q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
